// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259-compatible PIC interrupt mask logic.
package pic_pkg;

  localparam int          PIC_WIDTH   = 8;
  localparam logic [7:0]  IMR_RST_VAL = 8'h00;

  typedef enum logic [2:0] {
    MASK_NOP     = 3'b000,
    MASK_INIT    = 3'b001,
    MASK_WRITE   = 3'b010,
    MASK_SET     = 3'b011,
    MASK_CLR     = 3'b100,
    MASK_TGL     = 3'b101,
    MASK_SMM_SET = 3'b110,
    MASK_SMM_CLR = 3'b111
  } mask_op_e;

endpackage

// File: rtl/pic_imr_mask.sv
// Interrupt Mask Register with masked request vector for the 8259-compatible PIC.
// Optional special mask mode (ISR/SMM/INHIBIT) is enabled by `define PIC_SPECIAL_MASK_MODE_EN.
module pic_imr_mask
  import pic_pkg::*;
#(
  parameter int               WIDTH   = PIC_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(IMR_RST_VAL)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [2:0]       MODE,
  input  logic [WIDTH-1:0] DATA,
  input  logic [WIDTH-1:0] IRR,
  output logic [WIDTH-1:0] IMR,
  output logic [WIDTH-1:0] MASKED_IRR,
  output logic             ANY_REQ
`ifdef PIC_SPECIAL_MASK_MODE_EN
  ,
  input  logic [WIDTH-1:0] ISR,
  output logic             SMM,
  output logic [WIDTH-1:0] INHIBIT
`endif
);

  mask_op_e         mode_op;
  logic [WIDTH-1:0] imr_d;
  logic [WIDTH-1:0] imr_q;

  assign mode_op = mask_op_e'(MODE);

`ifdef PIC_SPECIAL_MASK_MODE_EN
  logic smm_d;
  logic smm_q;

  // Next-state decode for the mask register and special mask mode flag.
  always_comb begin
    imr_d = imr_q;
    smm_d = smm_q;
    case (mode_op)
      MASK_NOP:     imr_d = imr_q;
      MASK_INIT: begin
        imr_d = RST_VAL;
        smm_d = 1'b0;
      end
      MASK_WRITE:   imr_d = DATA;
      MASK_SET:     imr_d = imr_q | DATA;
      MASK_CLR:     imr_d = imr_q & ~DATA;
      MASK_TGL:     imr_d = imr_q ^ DATA;
      MASK_SMM_SET: smm_d = 1'b1;
      MASK_SMM_CLR: smm_d = 1'b0;
      default: begin
        imr_d = imr_q;
        smm_d = smm_q;
      end
    endcase
  end

  // Mask register and SMM flag with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      imr_q <= RST_VAL;
      smm_q <= 1'b0;
    end else begin
      imr_q <= imr_d;
      smm_q <= smm_d;
    end
  end

  // In special mask mode, masked in-service levels stop inhibiting lower priorities.
  assign SMM     = smm_q;
  assign INHIBIT = smm_q ? (ISR & ~imr_q) : ISR;
`else
  // Next-state decode for the mask register; the SMM codes are no-ops here.
  always_comb begin
    imr_d = imr_q;
    case (mode_op)
      MASK_NOP:     imr_d = imr_q;
      MASK_INIT:    imr_d = RST_VAL;
      MASK_WRITE:   imr_d = DATA;
      MASK_SET:     imr_d = imr_q | DATA;
      MASK_CLR:     imr_d = imr_q & ~DATA;
      MASK_TGL:     imr_d = imr_q ^ DATA;
      MASK_SMM_SET: imr_d = imr_q;
      MASK_SMM_CLR: imr_d = imr_q;
      default:      imr_d = imr_q;
    endcase
  end

  // Mask register with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      imr_q <= RST_VAL;
    end else begin
      imr_q <= imr_d;
    end
  end
`endif

  assign IMR        = imr_q;
  assign MASKED_IRR = IRR & ~imr_q;
  assign ANY_REQ    = |MASKED_IRR;

endmodule

// File: tb/tb_pic_imr_mask.sv
// Self-checking bench for pic_imr_mask: vector table plus scoreboard queue,
// hand-written combinational-path and (when enabled) special mask mode sequences.
module tb_pic_imr_mask;

  logic       clk;
  logic       rst;
  logic [2:0] mode;
  logic [7:0] data;
  logic [7:0] irr;
  logic [7:0] imr;
  logic [7:0] masked_irr;
  logic       any_req;
`ifdef PIC_SPECIAL_MASK_MODE_EN
  logic [7:0] isr;
  logic       smm;
  logic [7:0] inhibit;
`endif

  int errors;
  int checks;

  typedef struct {
    logic       rst;
    logic [2:0] mode;
    logic [7:0] data;
    logic [7:0] irr;
    logic [7:0] e_imr;
    logic [7:0] e_msk;
    logic       e_any;
  } vec_t;

  typedef struct {
    int         idx;
    logic [7:0] e_imr;
    logic [7:0] e_msk;
    logic       e_any;
  } exp_t;

  localparam int NVEC = 24;
  vec_t vecs[NVEC];
  exp_t sb_q[$];

  pic_imr_mask dut (
    .CLK        (clk),
    .RST        (rst),
    .MODE       (mode),
    .DATA       (data),
    .IRR        (irr),
    .IMR        (imr),
    .MASKED_IRR (masked_irr),
    .ANY_REQ    (any_req)
`ifdef PIC_SPECIAL_MASK_MODE_EN
    ,
    .ISR        (isr),
    .SMM        (smm),
    .INHIBIT    (inhibit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic r, input logic [2:0] m, input logic [7:0] d,
                              input logic [7:0] i, input logic [7:0] ei,
                              input logic [7:0] em, input logic ea);
    vec_t v;
    v.rst = r; v.mode = m; v.data = d; v.irr = i;
    v.e_imr = ei; v.e_msk = em; v.e_any = ea;
    return v;
  endfunction

  // Scoreboard monitor: pops one expectation per clock just after the edge
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      check($sformatf("vec%0d_imr", e.idx), imr, e.e_imr);
      check($sformatf("vec%0d_masked", e.idx), masked_irr, e.e_msk);
      check($sformatf("vec%0d_any", e.idx), {7'd0, any_req}, {7'd0, e.e_any});
    end
  end

  task automatic drive(input logic r, input logic [2:0] m, input logic [7:0] d, input logic [7:0] i);
    @(negedge clk);
    rst = r; mode = m; data = d; irr = i;
  endtask

  initial begin
    exp_t e;
    errors = 0;
    checks = 0;
    rst  = 1'b1;
    mode = 3'b000;
    data = 8'h00;
    irr  = 8'h00;
`ifdef PIC_SPECIAL_MASK_MODE_EN
    isr  = 8'h00;
`endif

    // rst, mode, data, irr -> imr, masked, any (values after the edge)
    vecs[0]  = mk(1'b1, 3'b010, 8'hAA, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[1]  = mk(1'b1, 3'b010, 8'hAA, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[2]  = mk(1'b1, 3'b010, 8'h55, 8'h00, 8'h00, 8'h00, 1'b0);
    vecs[3]  = mk(1'b0, 3'b010, 8'h55, 8'hFF, 8'h55, 8'hAA, 1'b1);
    vecs[4]  = mk(1'b0, 3'b010, 8'hF0, 8'h00, 8'hF0, 8'h00, 1'b0);
    vecs[5]  = mk(1'b0, 3'b011, 8'h0F, 8'h0F, 8'hFF, 8'h00, 1'b0);
    vecs[6]  = mk(1'b0, 3'b100, 8'h3C, 8'h3C, 8'hC3, 8'h3C, 1'b1);
    vecs[7]  = mk(1'b0, 3'b101, 8'hFF, 8'hFF, 8'h3C, 8'hC3, 1'b1);
    vecs[8]  = mk(1'b0, 3'b000, 8'hFF, 8'h3C, 8'h3C, 8'h00, 1'b0);
    vecs[9]  = mk(1'b0, 3'b000, 8'h00, 8'h3C, 8'h3C, 8'h00, 1'b0);
    vecs[10] = mk(1'b0, 3'b000, 8'h81, 8'h3C, 8'h3C, 8'h00, 1'b0);
    vecs[11] = mk(1'b0, 3'b010, 8'hA5, 8'hFF, 8'hA5, 8'h5A, 1'b1);
    vecs[12] = mk(1'b0, 3'b001, 8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1);
    vecs[13] = mk(1'b0, 3'b010, 8'h5A, 8'h0F, 8'h5A, 8'h05, 1'b1);
    vecs[14] = mk(1'b0, 3'b110, 8'hFF, 8'h0F, 8'h5A, 8'h05, 1'b1);
    vecs[15] = mk(1'b0, 3'b111, 8'h00, 8'h0F, 8'h5A, 8'h05, 1'b1);
    vecs[16] = mk(1'b0, 3'b010, 8'h12, 8'hFF, 8'h12, 8'hED, 1'b1);
    vecs[17] = mk(1'b0, 3'b010, 8'h34, 8'hFF, 8'h34, 8'hCB, 1'b1);
    vecs[18] = mk(1'b1, 3'b010, 8'h12, 8'hFF, 8'h00, 8'hFF, 1'b1);
    vecs[19] = mk(1'b0, 3'b010, 8'h34, 8'hFF, 8'h34, 8'hCB, 1'b1);
    vecs[20] = mk(1'b0, 3'b010, 8'h12, 8'hFF, 8'h12, 8'hED, 1'b1);
    vecs[21] = mk(1'b0, 3'b101, 8'h0F, 8'hFF, 8'h1D, 8'hE2, 1'b1);
    vecs[22] = mk(1'b0, 3'b011, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1'b0);
    vecs[23] = mk(1'b0, 3'b100, 8'hFF, 8'hFF, 8'h00, 8'hFF, 1'b1);

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].rst, vecs[i].mode, vecs[i].data, vecs[i].irr);
      e.idx = i; e.e_imr = vecs[i].e_imr; e.e_msk = vecs[i].e_msk; e.e_any = vecs[i].e_any;
      sb_q.push_back(e);
    end

    // Combinational masking: IRR changes reflect without waiting for an edge
    drive(1'b0, 3'b010, 8'h3C, 8'h00);
    e.idx = 100; e.e_imr = 8'h3C; e.e_msk = 8'h00; e.e_any = 1'b0;
    sb_q.push_back(e);
    drive(1'b0, 3'b000, 8'h00, 8'hFF);
    #1;
    check("comb_masked_ff", masked_irr, 8'hC3);
    check("comb_any_ff", {7'd0, any_req}, 8'h01);
    irr = 8'h3C;
    #1;
    check("comb_masked_3c", masked_irr, 8'h00);
    check("comb_any_3c", {7'd0, any_req}, 8'h00);
    irr = 8'h40;
    #1;
    check("comb_masked_40", masked_irr, 8'h40);
    check("comb_imr_hold", imr, 8'h3C);

`ifdef PIC_SPECIAL_MASK_MODE_EN
    drive(1'b0, 3'b010, 8'h08, 8'h00);
    isr = 8'h08;
    @(negedge clk);
    mode = 3'b000;
    check("smm_off", {7'd0, smm}, 8'h00);
    check("inhibit_smm0", inhibit, 8'h08);
    drive(1'b0, 3'b110, 8'h00, 8'h00);
    @(negedge clk);
    mode = 3'b000;
    check("smm_on", {7'd0, smm}, 8'h01);
    check("inhibit_smm1", inhibit, 8'h00);
    check("imr_smm_hold", imr, 8'h08);
    drive(1'b0, 3'b111, 8'h00, 8'h00);
    @(negedge clk);
    mode = 3'b000;
    check("smm_cleared", {7'd0, smm}, 8'h00);
    check("inhibit_back", inhibit, 8'h08);
    drive(1'b0, 3'b110, 8'h00, 8'h00);
    drive(1'b0, 3'b001, 8'h00, 8'h00);
    @(negedge clk);
    mode = 3'b000;
    check("init_clears_smm", {7'd0, smm}, 8'h00);
    check("init_clears_imr", imr, 8'h00);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 8'(sb_q.size()), 8'h00);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
